regfile_preloader: RTL and testbench

- Inverse of the register-dump harness: loads a list of (register, value) pairs into the regfile write port before the processor runs.
- Processor is held in reset while the list loads, then released after a fixed hold.
- Sits between a stimulus source (bench or debug link) and the regfile write-port mux in the wrapper. `load_active` selects the preloader over the CPU's write port.

---
 rtl/regfile_preloader.sv | 93 +++++++++
 tb/tb_regfile_preloader.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_preloader.sv
// regfile_preloader: loads (register, value) pairs into the regfile while the CPU is held in reset; define REGLOAD_CLEAR_EN to zero r1..r31 first
module regfile_preloader #(
  parameter int HOLD_CYCLES = 2,
  parameter int CNT_W = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  input  logic [4:0] in_reg,
  input  logic [31:0] in_data,
  input  logic in_last,
  output logic load_active,
  output logic ctrl_writeEnable,
  output logic [4:0] ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic cpu_reset,
  output logic done,
  output logic [CNT_W-1:0] words_loaded,
  output logic r0_dropped
);
  localparam int HW = HOLD_CYCLES < 2 ? 1 : $clog2(HOLD_CYCLES + 1);
`ifdef REGLOAD_CLEAR_EN
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, DRAIN, HOLD, RUN} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, HOLD, RUN} state_t;
`endif
  state_t state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic acc;
  assign acc = in_valid && state == LOAD;
  // state-decoded handshake/control outputs and next-state selection
  always_comb begin
    state_nx = state;
    in_ready = state == LOAD;
    load_active = state != IDLE && state != RUN;
    cpu_reset = state != RUN;
    done = state == RUN;
    case (state)
`ifdef REGLOAD_CLEAR_EN
      IDLE: state_nx = start ? CLEAR : IDLE;
      CLEAR: state_nx = ctrl_writeReg == 5'd31 ? LOAD : CLEAR;
`else
      IDLE: state_nx = start ? LOAD : IDLE;
`endif
      LOAD: state_nx = in_valid && in_last ? DRAIN : LOAD;
      DRAIN: state_nx = HOLD;
      HOLD: state_nx = hold_cnt == HW'(1) ? RUN : HOLD;
      default: state_nx = state;
    endcase
  end
  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  // registered write port, hold timer and load statistics; r0 words are counted but never written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      hold_cnt <= '0;
      words_loaded <= '0;
      r0_dropped <= 1'b0;
    end else begin
      ctrl_writeEnable <= acc && in_reg != 5'd0;
      if (acc) begin
        ctrl_writeReg <= in_reg;
        data_writeReg <= in_data;
        if (words_loaded != '1) words_loaded <= words_loaded + 1'b1;
        if (in_reg == 5'd0) r0_dropped <= 1'b1;
      end
      if (state == IDLE && start) begin
        words_loaded <= '0;
        r0_dropped <= 1'b0;
`ifdef REGLOAD_CLEAR_EN
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg <= 5'd1;
        data_writeReg <= '0;
`endif
      end
`ifdef REGLOAD_CLEAR_EN
      if (state == CLEAR && ctrl_writeReg != 5'd31) begin
        ctrl_writeEnable <= 1'b1;
        ctrl_writeReg <= ctrl_writeReg + 5'd1;
      end
`endif
      hold_cnt <= state == DRAIN ? HW'(HOLD_CYCLES) : hold_cnt - HW'(state == HOLD);
    end
  end
endmodule

// File: tb/tb_regfile_preloader.sv
// tb_regfile_preloader: randomized load sequences checked against a timeline model of the preloader
module tb_regfile_preloader;
  localparam int H = 2;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
`ifdef REGLOAD_CLEAR_EN
  localparam int CLR = 31;
`else
  localparam int CLR = 0;
`endif
  logic clock = 0, reset = 0, start = 0, in_valid = 0, in_last = 0;
  logic [4:0] in_reg = 0;
  logic [31:0] in_data = 0;
  logic in_ready, load_active, ctrl_writeEnable, cpu_reset, done, r0_dropped;
  logic [4:0] ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [CW-1:0] words_loaded;
  int nchk = 0, nfail = 0;
  typedef struct { int c; int r; logic [31:0] d; } wr_t;
  wr_t wq[$];
  logic [31:0] rf [32];
  logic [31:0] mrf [32];
  int cyc = 0, ts = 0, last_acc = -1, m_words = 0;
  bit active = 0, m_r0 = 0;

  always #5 clock = ~clock;

  regfile_preloader #(.HOLD_CYCLES(H), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .in_last(in_last), .load_active(load_active),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .cpu_reset(cpu_reset), .done(done), .words_loaded(words_loaded), .r0_dropped(r0_dropped)
  );

  function automatic logic [31:0] seed(int i);
    return i == 0 ? 32'd0 : i == 6 ? 32'd11 : 32'h100 + i;
  endfunction
  function automatic int run_at();
    return last_acc < 0 ? 32'h7fffffff : last_acc + 2 + H;
  endfunction
  function automatic bit e_ready(int c);
    return active && c >= ts + 1 + CLR && (last_acc < 0 || c <= last_acc);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // regfile as the wrapper would see it through the DUT write port
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = seed(i);
    forever begin
      @(posedge clock);
      if (reset && ctrl_writeEnable) rf[ctrl_writeReg] = data_writeReg;
    end
  end

  // timeline model: tracks start cycle, accepted words and the cycle of the last word
  initial begin
    for (int i = 0; i < 32; i++) mrf[i] = seed(i);
    forever begin
      @(posedge clock);
      if (!reset) begin
        active = 0;
        last_acc = -1;
        m_words = 0;
        m_r0 = 0;
        wq.delete();
      end else begin
        while (wq.size() > 0 && wq[0].c <= cyc) begin
          if (wq[0].c == cyc) mrf[wq[0].r] = wq[0].d;
          void'(wq.pop_front());
        end
        if (!active && start) begin
          active = 1;
          ts = cyc;
          last_acc = -1;
          m_words = 0;
          m_r0 = 0;
          for (int k = 0; k < CLR; k++) wq.push_back('{c: cyc + 1 + k, r: k + 1, d: 32'd0});
        end else if (in_valid && e_ready(cyc)) begin
          if (m_words < SAT) m_words++;
          if (in_reg == 0) m_r0 = 1;
          else wq.push_back('{c: cyc + 1, r: int'(in_reg), d: in_data});
          if (in_last) last_acc = cyc;
        end
      end
      cyc++;
    end
  end

  // per-cycle comparison of every output against the model
  initial begin
    bit ew;
    wr_t e;
    forever begin
      @(negedge clock);
      if (!reset) begin
        check("rst_in_ready", in_ready, 0);
        check("rst_load_active", load_active, 0);
        check("rst_we", ctrl_writeEnable, 0);
        check("rst_wreg", ctrl_writeReg, 0);
        check("rst_wdata", data_writeReg, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_done", done, 0);
        check("rst_words", words_loaded, 0);
        check("rst_r0", r0_dropped, 0);
      end else begin
        ew = 0;
        foreach (wq[i]) if (wq[i].c == cyc) begin ew = 1; e = wq[i]; end
        check("in_ready", in_ready, e_ready(cyc));
        check("load_active", load_active, active && cyc >= ts + 1 && cyc < run_at());
        check("cpu_reset", cpu_reset, !(active && cyc >= run_at()));
        check("done", done, active && cyc >= run_at());
        check("we", ctrl_writeEnable, ew);
        if (ew) begin
          check("wreg", ctrl_writeReg, e.r);
          check("wdata", data_writeReg, e.d);
        end
        check("words", words_loaded, m_words);
        check("r0_dropped", r0_dropped, m_r0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 0;
    tick();
    tick();
    reset = 1;
  endtask
  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic send(int r, logic [31:0] d, bit last);
    int n = 0;
    in_valid = 1;
    in_reg = 5'(r);
    in_data = d;
    in_last = last;
    @(negedge clock);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clock);
    end
    check("accept_wait", n < 200, 1);
    tick();
    in_valid = 0;
    in_last = 0;
    in_reg = 5'($urandom);
    in_data = $urandom;
  endtask
  task automatic wait_done();
    int n = 0;
    @(negedge clock);
    while (!done && n < 300) begin
      n++;
      @(negedge clock);
    end
    check("done_wait", n < 300, 1);
    tick();
  endtask
  task automatic dump_check();
    for (int i = 0; i < 32; i++) check($sformatf("rf_r%0d", i), rf[i], mrf[i]);
  endtask

  initial begin
    int n, len;
    bit cut;
    reset = 0;
    tick();
    tick();
    tick();
    reset = 1;
    @(negedge clock);
    check("idle_cpu_reset", cpu_reset, 1);
    check("idle_done", done, 0);
    check("idle_load_active", load_active, 0);
    check("idle_words", words_loaded, 0);
    tick();
`ifdef REGLOAD_CLEAR_EN
    check("clr_pre_r6", rf[6], 11);
    do_start();
    send(1, 1, 1);
    wait_done();
    check("clr_r6", rf[6], 0);
    check("clr_r1", rf[1], 1);
    check("clr_words", words_loaded, 1);
    do_reset();
`endif
    do_start();
    send(1, 5, 0);
    send(2, 32'hFFFFFFFD, 0);
    send(31, 32'h7FFFFFFF, 1);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (cpu_reset && n < 50);
    check("release_delay", n - 1, 1 + H);
    check("words3", words_loaded, 3);
    check("r1", rf[1], 5);
    check("r2", rf[2], 32'hFFFFFFFD);
    check("r31", rf[31], 32'h7FFFFFFF);
    tick();
    start = 1;
    tick();
    start = 0;
    @(negedge clock);
    check("run_ignores_start_done", done, 1);
    check("run_ignores_start_la", load_active, 0);
    tick();
    do_reset();
    do_start();
    send(0, 99, 0);
    send(4, 7, 1);
    wait_done();
    check("r0_dropped_set", r0_dropped, 1);
    check("words2", words_loaded, 2);
    check("r4", rf[4], 7);
    check("r0", rf[0], 0);
    do_reset();
    do_start();
    send(3, 1, 0);
    tick();
    send(3, 2, 1);
    @(negedge clock);
    check("ready_after_last", in_ready, 0);
    wait_done();
    check("r3", rf[3], 2);
    do_reset();
    do_start();
    send(5, 9, 0);
    do_reset();
    check("r5_dropped", rf[5], CLR ? 32'd0 : seed(5));
    do_start();
    send(5, 9, 1);
    wait_done();
    check("r5_reload", rf[5], 9);
    check("words1", words_loaded, 1);
`ifndef REGLOAD_CLEAR_EN
    check("r6_kept", rf[6], 11);
`endif
    do_reset();
    do_start();
    for (int k = 0; k < 20; k++) send($urandom_range(1, 31), $urandom, k == 19);
    wait_done();
    check("words_sat", words_loaded, SAT);
    dump_check();
    do_reset();
    for (int s = 0; s < 12; s++) begin
      len = $urandom_range(1, 12);
      cut = $urandom_range(0, 3) == 0;
      in_valid = 1;
      in_reg = 5'($urandom);
      in_data = $urandom;
      tick();
      in_valid = 0;
      do_start();
      for (int k = 0; k < len; k++) begin
        send($urandom_range(0, 31), $urandom, k == len - 1);
        if (cut && k == len / 2 && k < len - 1) break;
        repeat ($urandom_range(0, 2)) tick();
      end
      if (!cut) begin
        wait_done();
        start = 1;
        tick();
        start = 0;
        tick();
      end
      do_reset();
      dump_check();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", nchk, nfail);
    $fatal(1);
  end
endmodule
